byte_serial_transfer_unit: RTL and testbench

- Parametrised burst engine between the byte-wide Memory and wide datapath registers (RF/ARF/IR), replacing hand-sequenced two-cycle LH loads.
- Load mode: assembles DATA_W-bit words from consecutive bytes and presents them to the datapath.
- Store mode: serialises DATA_W-bit words into consecutive bytes.
- Supports bursts of WordCount words, auto-incrementing the address, with start/busy/done control handshakes.

---
 rtl/transfer_pkg.sv | 20 ++
 rtl/byte_lane_shifter.sv | 68 ++++++
 rtl/byte_serial_transfer_unit.sv | 153 +++++++++++++++
 tb/tb_byte_serial_transfer_unit.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/transfer_pkg.sv
// Shared types and constants for the byte-serial transfer unit.
package transfer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DATA,
        XFER,
        FINISH
    } state_t;

    localparam logic MODE_LOAD  = 1'b0;
    localparam logic MODE_STORE = 1'b1;
    localparam logic CS_ACTIVE  = 1'b0;

    // Width of a byte-index counter; a one-byte word still needs one bit.
    function automatic int idx_width(input int bytes);
        return (bytes > 1) ? $clog2(bytes) : 1;
    endfunction

endpackage

// File: rtl/byte_lane_shifter.sv
// Byte lane datapath: inserts read bytes into a word for loads, selects
// the current byte of a held word for stores, and tracks the byte index.
module byte_lane_shifter
    import transfer_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load_word,
    input  logic [DATA_W-1:0] store_word,
    input  logic              advance,
    input  logic              insert,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] assembled,
    output logic [7:0]        byte_out,
    output logic              last
);

    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = idx_width(BYTES);

    logic [DATA_W-1:0] word_q;
    logic [IDX_W-1:0]  idx_q;

    // Current word with the incoming byte dropped into the active lane,
    // and the active lane of the held word for writing out.
    always_comb begin
        // NOTE: every combinational output is given a default before the
        // lane loop so no path through the block can infer a latch.
        assembled = word_q;
        byte_out  = '0;
        for (int k = 0; k < BYTES; k++) begin
            if (idx_q == IDX_W'(k)) begin
                assembled[8*k +: 8] = byte_in;
                byte_out            = word_q[8*k +: 8];
            end
        end
    end

    assign last = (idx_q == IDX_W'(BYTES - 1));

    // Word register and byte index; the index wraps at the end of each word.
    always_ff @(posedge clk) begin
        // NOTE: all state updates are non-blocking so every read in this
        // block sees the value from before the clock edge.
        if (rst) begin
            // NOTE: the word register is data, but it is reset anyway so
            // the byte driven toward memory is defined straight out of reset.
            word_q <= '0;
            idx_q  <= '0;
        end else if (load_word) begin
            word_q <= store_word;
            idx_q  <= '0;
        end else begin
            if (clear) begin
                idx_q <= '0;
            end else if (advance) begin
                idx_q <= last ? '0 : idx_q + 1'b1;
            end
            if (advance && insert) begin
                word_q <= assembled;
            end
        end
    end

endmodule

// File: rtl/byte_serial_transfer_unit.sv
// Burst engine moving DATA_W-bit words between a byte-wide memory and the
// datapath, one byte per cycle, little-endian, with auto-incrementing address.
module byte_serial_transfer_unit
    import transfer_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Mode,
    input  logic [ADDR_W-1:0] BaseAddr,
    input  logic [CNT_W-1:0]  WordCount,
    input  logic [DATA_W-1:0] StoreData,
    input  logic              StoreValid,
    output logic              StoreReady,
    output logic [DATA_W-1:0] LoadData,
    output logic              LoadValid,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic              Mem_CS,
    output logic              Mem_WR,
    output logic [7:0]        Mem_DataOut,
    input  logic [7:0]        Mem_DataIn
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              mode_q;
    logic [DATA_W-1:0] load_data_q;
    logic              load_valid_q;

    logic              start_take;
    logic              store_take;
    logic              in_xfer;
    logic              last_word;
    logic              last;
    logic [DATA_W-1:0] assembled;
    logic [7:0]        byte_out;

    assign start_take = (state_q == IDLE) && Start;
    assign store_take = (state_q == WAIT_DATA) && StoreValid;
    assign in_xfer    = (state_q == XFER);
    assign last_word  = (cnt_q == CNT_W'(1));

    byte_lane_shifter #(
        .DATA_W(DATA_W)
    ) u_lanes (
        .clk       (Clock),
        .rst       (Reset),
        .clear     (start_take),
        .load_word (store_take),
        .store_word(StoreData),
        .advance   (in_xfer),
        .insert    (mode_q == MODE_LOAD),
        .byte_in   (Mem_DataIn),
        .assembled (assembled),
        .byte_out  (byte_out),
        .last      (last)
    );

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the Done/StoreReady strobes. FINISH waits out the
    // final LoadValid cycle so Done always trails the last loaded word.
    always_comb begin
        state_d    = state_q;
        Done       = 1'b0;
        StoreReady = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    if (WordCount == '0) begin
                        state_d = FINISH;
                    end else if (Mode == MODE_STORE) begin
                        state_d = WAIT_DATA;
                    end else begin
                        state_d = XFER;
                    end
                end
            end
            WAIT_DATA: begin
                StoreReady = 1'b1;
                if (StoreValid) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (last) begin
                    if (last_word) begin
                        state_d = FINISH;
                    end else if (mode_q == MODE_STORE) begin
                        state_d = WAIT_DATA;
                    end
                end
            end
            FINISH: begin
                if (!load_valid_q) begin
                    Done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Burst context: address, remaining words, mode, and the load result.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            addr_q       <= '0;
            cnt_q        <= '0;
            mode_q       <= MODE_LOAD;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
        end else begin
            load_valid_q <= 1'b0;
            if (start_take) begin
                addr_q <= BaseAddr;
                cnt_q  <= WordCount;
                mode_q <= Mode;
            end else if (in_xfer) begin
                addr_q <= addr_q + 1'b1;
                if (last) begin
                    cnt_q <= cnt_q - 1'b1;
                    if (mode_q == MODE_LOAD) begin
                        load_data_q  <= assembled;
                        load_valid_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign Busy        = (state_q != IDLE);
    assign Mem_Address = addr_q;
    assign Mem_CS      = in_xfer ? CS_ACTIVE : ~CS_ACTIVE;
    assign Mem_WR      = in_xfer && (mode_q == MODE_STORE);
    assign Mem_DataOut = Mem_WR ? byte_out : 8'h00;
    assign LoadData    = load_data_q;
    assign LoadValid   = load_valid_q;

endmodule

// File: tb/tb_byte_serial_transfer_unit.sv
// Scoreboard bench: stimulus pushes expected load words and memory writes,
// a negedge monitor pops and compares them as the unit presents them.
module tb_byte_serial_transfer_unit;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int CNT_W  = 8;
    localparam int BYTES  = DATA_W / 8;

    logic              Clock = 1'b0;
    logic              Reset;
    logic              Start;
    logic              Mode;
    logic [ADDR_W-1:0] BaseAddr;
    logic [CNT_W-1:0]  WordCount;
    logic [DATA_W-1:0] StoreData;
    logic              StoreValid;
    logic              StoreReady;
    logic [DATA_W-1:0] LoadData;
    logic              LoadValid;
    logic              Busy;
    logic              Done;
    logic [ADDR_W-1:0] Mem_Address;
    logic              Mem_CS;
    logic              Mem_WR;
    logic [7:0]        Mem_DataOut;
    logic [7:0]        Mem_DataIn;

    byte_serial_transfer_unit #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (Start),
        .Mode       (Mode),
        .BaseAddr   (BaseAddr),
        .WordCount  (WordCount),
        .StoreData  (StoreData),
        .StoreValid (StoreValid),
        .StoreReady (StoreReady),
        .LoadData   (LoadData),
        .LoadValid  (LoadValid),
        .Busy       (Busy),
        .Done       (Done),
        .Mem_Address(Mem_Address),
        .Mem_CS     (Mem_CS),
        .Mem_WR     (Mem_WR),
        .Mem_DataOut(Mem_DataOut),
        .Mem_DataIn (Mem_DataIn)
    );

    always #5 Clock = ~Clock;

    // Byte-wide memory: combinational read, write on the rising edge.
    logic [7:0] mem [0:65535];
    assign Mem_DataIn = mem[Mem_Address];

    always @(posedge Clock) begin
        if (Mem_CS == 1'b0 && Mem_WR == 1'b1) begin
            mem[Mem_Address] <= Mem_DataOut;
        end
    end

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    int                checks = 0;
    int                errors = 0;
    logic [DATA_W-1:0] exp_load [$];
    wr_t               exp_wr [$];
    int                done_seen = 0;
    logic [DATA_W-1:0] mon_word;
    wr_t               mon_wr;

    int                lv_cyc [$];
    logic [15:0]       addr_seen [$];
    int                done_cyc;
    int                busy_cnt;
    int                cs_cnt;
    logic [DATA_W-1:0] st_words [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the unit presents a result.
    always @(negedge Clock) begin
        if (LoadValid === 1'b1) begin
            check("load_expected", 32'(LoadValid), 32'(exp_load.size() != 0));
            if (exp_load.size() != 0) begin
                mon_word = exp_load.pop_front();
                check("load_data", 32'(LoadData), 32'(mon_word));
            end
        end
        if (Mem_CS === 1'b0 && Mem_WR === 1'b1) begin
            check("write_expected", 32'(Mem_WR), 32'(exp_wr.size() != 0));
            if (exp_wr.size() != 0) begin
                mon_wr = exp_wr.pop_front();
                check("write_addr", 32'(Mem_Address), 32'(mon_wr.addr));
                check("write_data", 32'(Mem_DataOut), 32'(mon_wr.data));
            end
        end
        if (Done === 1'b1) begin
            done_seen++;
        end
    end

    // Little-endian reference: byte k of word w lives at base + w*BYTES + k.
    function automatic logic [15:0] byte_addr(input logic [15:0] base, input int w, input int k);
        return 16'((int'(base) + w * BYTES + k) % 65536);
    endfunction

    task automatic run_load(input logic [15:0] base, input logic [7:0] wc, input bit poke);
        logic [DATA_W-1:0] word;
        int                d0;
        int                exp_done;
        for (int w = 0; w < int'(wc); w++) begin
            word = '0;
            for (int k = 0; k < BYTES; k++) begin
                word = word | (DATA_W'(mem[byte_addr(base, w, k)]) << (8 * k));
            end
            exp_load.push_back(word);
        end
        lv_cyc.delete();
        addr_seen.delete();
        done_cyc = 0;
        busy_cnt = 0;
        cs_cnt   = 0;
        d0       = done_seen;
        @(posedge Clock); #1;
        Start = 1'b1; Mode = 1'b0; BaseAddr = base; WordCount = wc;
        @(posedge Clock); #1;
        Start = 1'b0;
        for (int n = 1; n <= 400; n++) begin
            @(negedge Clock);
            if (Busy) busy_cnt++;
            if (Mem_CS == 1'b0) begin
                cs_cnt++;
                addr_seen.push_back(Mem_Address);
            end
            if (LoadValid) lv_cyc.push_back(n);
            if (poke && n == 2) begin
                Start = 1'b1; Mode = 1'b1; WordCount = 8'd5; BaseAddr = 16'h0000;
            end
            if (Done) begin
                done_cyc = n;
                break;
            end
            @(posedge Clock); #1;
            Start = 1'b0;
        end
        exp_done = (wc == 0) ? 1 : BYTES * int'(wc) + 2;
        check("load_done_cycle", 32'(done_cyc), 32'(exp_done));
        check("load_busy_cycles", 32'(busy_cnt), 32'(exp_done));
        check("load_cs_cycles", 32'(cs_cnt), 32'(BYTES * int'(wc)));
        check("load_valid_count", 32'(lv_cyc.size()), 32'(wc));
        for (int i = 0; i < lv_cyc.size(); i++) begin
            check("load_valid_cycle", 32'(lv_cyc[i]), 32'(BYTES * (i + 1) + 1));
        end
        for (int i = 0; i < addr_seen.size(); i++) begin
            check("load_addr", 32'(addr_seen[i]), 32'(byte_addr(base, 0, i)));
        end
        @(negedge Clock);
        check("load_idle_after_done", 32'(Busy), 32'(0));
        check("load_done_pulses", 32'(done_seen - d0), 32'(1));
    endtask

    task automatic run_store(input logic [15:0] base, input logic [7:0] wc, input int stall);
        int d0;
        int t;
        d0 = done_seen;
        @(posedge Clock); #1;
        Start = 1'b1; Mode = 1'b1; BaseAddr = base; WordCount = wc;
        @(posedge Clock); #1;
        Start = 1'b0;
        for (int w = 0; w < int'(wc); w++) begin
            t = 0;
            @(negedge Clock);
            while (!StoreReady && t < 50) begin
                @(negedge Clock);
                t++;
            end
            check("store_ready_seen", 32'(StoreReady), 32'(1));
            for (int s = 0; s < stall; s++) begin
                check("stall_cs_high", 32'(Mem_CS), 32'(1));
                check("stall_ready", 32'(StoreReady), 32'(1));
                @(negedge Clock);
            end
            StoreValid = 1'b1;
            StoreData  = st_words[w];
            for (int k = 0; k < BYTES; k++) begin
                exp_wr.push_back('{addr: byte_addr(base, w, k), data: st_words[w][8*k +: 8]});
            end
            @(posedge Clock); #1;
            StoreValid = 1'b0;
        end
        t = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge Clock);
            if (Done) begin
                t = i;
                break;
            end
        end
        check("store_done_latency", 32'(t), 32'(BYTES + 1));
        for (int w = 0; w < int'(wc); w++) begin
            for (int k = 0; k < BYTES; k++) begin
                check("store_mem", 32'(mem[byte_addr(base, w, k)]), 32'(st_words[w][8*k +: 8]));
            end
        end
        @(negedge Clock);
        check("store_idle_after_done", 32'(Busy), 32'(0));
        check("store_done_pulses", 32'(done_seen - d0), 32'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0] keep52;
        int         d0;
        Reset = 1'b1; Start = 1'b0; Mode = 1'b0; BaseAddr = '0; WordCount = '0;
        StoreData = '0; StoreValid = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] <= 8'($urandom);
        repeat (3) @(posedge Clock);
        #1 Reset = 1'b0;
        @(negedge Clock);
        check("rst_busy", 32'(Busy), 32'(0));
        check("rst_cs", 32'(Mem_CS), 32'(1));
        check("rst_wr", 32'(Mem_WR), 32'(0));
        check("rst_addr", 32'(Mem_Address), 32'(0));
        check("rst_dout", 32'(Mem_DataOut), 32'(0));
        check("rst_ldata", 32'(LoadData), 32'(0));
        check("rst_lvalid", 32'(LoadValid), 32'(0));
        check("rst_done", 32'(Done), 32'(0));
        check("rst_sready", 32'(StoreReady), 32'(0));

        // Single-word load with known bytes.
        mem[16'h0010] <= 8'h34;
        mem[16'h0011] <= 8'h12;
        @(posedge Clock); #1;
        run_load(16'h0010, 8'd1, 1'b0);
        check("ld1_word", 32'(LoadData), 32'h1234);

        // Three-word burst, with a Start poked mid-burst that must be ignored.
        run_load(16'h0020, 8'd3, 1'b1);

        // Store with a three-cycle StoreValid stall.
        st_words[0] = 16'hBEEF;
        run_store(16'h0040, 8'd1, 3);
        check("st_lo", 32'(mem[16'h0040]), 32'hEF);
        check("st_hi", 32'(mem[16'h0041]), 32'hBE);

        // Address wrap across the top of memory.
        mem[16'hFFFF] <= 8'hAB;
        mem[16'h0000] <= 8'hCD;
        @(posedge Clock); #1;
        run_load(16'hFFFF, 8'd1, 1'b0);
        check("wrap_word", 32'(LoadData), 32'hCDAB);

        // Empty burst.
        run_load(16'h0030, 8'd0, 1'b0);

        // Reset in the middle of a two-word store.
        keep52 = mem[16'h0052];
        d0 = done_seen;
        @(posedge Clock); #1;
        Start = 1'b1; Mode = 1'b1; BaseAddr = 16'h0050; WordCount = 8'd2;
        @(posedge Clock); #1;
        Start = 1'b0;
        @(negedge Clock);
        check("mid_ready", 32'(StoreReady), 32'(1));
        Start = 1'b1; Mode = 1'b0; WordCount = 8'd1;
        StoreValid = 1'b1; StoreData = 16'hA55A;
        exp_wr.push_back('{addr: 16'h0050, data: 8'h5A});
        exp_wr.push_back('{addr: 16'h0051, data: 8'hA5});
        @(posedge Clock); #1;
        Start = 1'b0; StoreValid = 1'b0;
        @(posedge Clock); #1;
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        @(negedge Clock);
        check("mid_rst_busy", 32'(Busy), 32'(0));
        check("mid_rst_cs", 32'(Mem_CS), 32'(1));
        check("mid_rst_ready", 32'(StoreReady), 32'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            check("mid_rst_stays_idle", 32'(Busy), 32'(0));
        end
        check("mid_rst_no_done", 32'(done_seen - d0), 32'(0));
        check("mid_rst_byte0", 32'(mem[16'h0050]), 32'h5A);
        check("mid_rst_untouched", 32'(mem[16'h0052]), 32'(keep52));
        check("mid_rst_wr_drained", 32'(exp_wr.size()), 32'(0));
        exp_wr.delete();

        // Randomised bursts of both kinds.
        for (int r = 0; r < 12; r++) begin
            logic [15:0] base;
            logic [7:0]  wc;
            base = 16'($urandom);
            wc   = 8'($urandom_range(1, 4));
            if ($urandom_range(0, 1) == 0) begin
                run_load(base, wc, 1'b0);
            end else begin
                for (int w = 0; w < 4; w++) st_words[w] = DATA_W'($urandom);
                run_store(base, wc, int'($urandom_range(0, 3)));
            end
        end

        repeat (2) @(negedge Clock);
        check("load_queue_empty", 32'(exp_load.size()), 32'(0));
        check("write_queue_empty", 32'(exp_wr.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
